// File: rtl/opendap_ap_mux.sv
// Routes the SW-DP's single AP port to one of N_AP downstream APs, holds the
// response routing for the whole transaction and aborts hung APs via a watchdog.
module opendap_ap_mux #(
    parameter int N_AP         = 2,
    parameter int UNMAPPED_ERR = 0,
    parameter int TIMEOUT      = 0
) (
    input  logic                 swclk,
    input  logic                 rst_n,
    input  logic [7:0]           up_sel,
    input  logic [5:0]           up_addr,
    input  logic [31:0]          up_wdata,
    input  logic                 up_wen,
    input  logic                 up_ren,
    input  logic                 up_abort,
    output logic [31:0]          up_rdata,
    output logic                 up_rdy,
    output logic                 up_err,
    output logic [5:0]           dn_addr,
    output logic [31:0]          dn_wdata,
    output logic [N_AP-1:0]      dn_wen,
    output logic [N_AP-1:0]      dn_ren,
    output logic [N_AP-1:0]      dn_abort,
    input  logic [32*N_AP-1:0]   dn_rdata,
    input  logic [N_AP-1:0]      dn_rdy,
    input  logic [N_AP-1:0]      dn_err
);

    localparam logic [7:0]  N_AP_SEL      = 8'(N_AP);
    localparam logic [15:0] TMO_LAST      = 16'(TIMEOUT - 1);
    localparam logic        TMO_EN        = (TIMEOUT != 0);
    localparam logic        UNMAP_ERR_BIT = (UNMAPPED_ERR != 0);

    logic [7:0]  act_sel;
    logic        pending;
    logic        unmapped;
    logic [15:0] tmo_cnt;
    logic        tmo_err;

    logic        req;
    logic        sel_rdy;
    logic        sel_err;
    logic [31:0] sel_rdata;
    logic        tmo_busy;
    logic        tmo_fire;

    // Handshake: a request is a one-cycle up_wen/up_ren pulse issued only while
    // up_rdy=1; the transaction completes on the first cycle up_rdy=1 after it,
    // and up_err is meaningful only on that cycle (or the watchdog error cycle).
    assign req      = up_wen | up_ren;
    assign dn_addr  = up_addr;
    assign dn_wdata = up_wdata;

    // Response side follows the latched act_sel, never the live up_sel.
    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        dn_wen    = '0;
        dn_ren    = '0;
        for (int i = 0; i < N_AP; i++) begin
            if (act_sel == 8'(i)) begin
                sel_rdy   = dn_rdy[i];
                sel_err   = dn_err[i];
                sel_rdata = dn_rdata[32*i +: 32];
            end
            if (up_sel == 8'(i)) begin
                dn_wen[i] = rst_n && up_wen;
                dn_ren[i] = rst_n && up_ren;
            end
        end
    end

    assign tmo_busy = pending && !unmapped && !sel_rdy;
    assign tmo_fire = TMO_EN && tmo_busy && (tmo_cnt == TMO_LAST);

    always_comb begin
        dn_abort = '0;
        for (int i = 0; i < N_AP; i++) begin
            if (rst_n && act_sel == 8'(i)) begin
                dn_abort[i] = up_abort || tmo_fire;
            end
        end
    end

    assign up_rdy   = !pending || unmapped || sel_rdy;
    assign up_rdata = unmapped ? 32'h0 : sel_rdata;
    assign up_err   = (pending && up_rdy && (unmapped ? UNMAP_ERR_BIT : sel_err)) || tmo_err;

    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            act_sel  <= '0;
            pending  <= 1'b0;
            unmapped <= 1'b0;
            tmo_cnt  <= '0;
            tmo_err  <= 1'b0;
        end else begin
            tmo_err <= tmo_fire;
            if (req) begin
                // A new request overrides any completion in the same cycle.
                act_sel  <= up_sel;
                pending  <= 1'b1;
                unmapped <= (up_sel >= N_AP_SEL);
                tmo_cnt  <= '0;
            end else begin
                if ((pending && up_rdy) || up_abort || tmo_fire) begin
                    pending <= 1'b0;
                end
                if (tmo_busy && tmo_cnt != 16'hFFFF) begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
            end
        end
    end

    a_no_dual_req : assert property (@(posedge swclk) disable iff (!rst_n)
        !(up_wen && up_ren));
    a_req_when_rdy : assert property (@(posedge swclk) disable iff (!rst_n)
        req |-> up_rdy);

endmodule

// File: tb/tb_opendap_ap_mux.sv
// Randomized and directed bench for opendap_ap_mux against a transaction-level
// timeline model (N_AP=2, UNMAPPED_ERR=1, TIMEOUT=4).
module tb_opendap_ap_mux;

    localparam int N_AP    = 2;
    localparam int TIMEOUT = 4;

    logic                swclk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          up_sel = '0;
    logic [5:0]          up_addr = '0;
    logic [31:0]         up_wdata = '0;
    logic                up_wen = 1'b0;
    logic                up_ren = 1'b0;
    logic                up_abort = 1'b0;
    logic [31:0]         up_rdata;
    logic                up_rdy;
    logic                up_err;
    logic [5:0]          dn_addr;
    logic [31:0]         dn_wdata;
    logic [N_AP-1:0]     dn_wen;
    logic [N_AP-1:0]     dn_ren;
    logic [N_AP-1:0]     dn_abort;
    logic [32*N_AP-1:0]  dn_rdata = '0;
    logic [N_AP-1:0]     dn_rdy = '1;
    logic [N_AP-1:0]     dn_err = '0;

    opendap_ap_mux #(.N_AP(N_AP), .UNMAPPED_ERR(1), .TIMEOUT(TIMEOUT)) dut (
        .swclk(swclk), .rst_n(rst_n),
        .up_sel(up_sel), .up_addr(up_addr), .up_wdata(up_wdata),
        .up_wen(up_wen), .up_ren(up_ren), .up_abort(up_abort),
        .up_rdata(up_rdata), .up_rdy(up_rdy), .up_err(up_err),
        .dn_addr(dn_addr), .dn_wdata(dn_wdata),
        .dn_wen(dn_wen), .dn_ren(dn_ren), .dn_abort(dn_abort),
        .dn_rdata(dn_rdata), .dn_rdy(dn_rdy), .dn_err(dn_err)
    );

    always #5 swclk = ~swclk;

    int n_checks = 0;
    int n_fail   = 0;
    int last_sel = 0;
    bit last_mapped = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_aps();
        for (int i = 0; i < N_AP; i++) begin
            dn_rdata[32*i +: 32] = $urandom;
            dn_rdy[i] = 1'($urandom);
            dn_err[i] = 1'($urandom);
        end
    endtask

    function automatic logic [31:0] ap_word(input int sel);
        return dn_rdata[32*sel +: 32];
    endfunction

    // One transaction: the selected AP holds rdy low for lat cycles after the
    // request; abort_at (0 = none) pulses DAPABORT in that busy cycle.
    task automatic run_txn(input int sel, input bit wr, input int lat, input bit err_bit,
                           input int abort_at, input logic [31:0] data);
        logic [N_AP-1:0] sel_mask;
        logic [5:0]      addr;
        logic [31:0]     wd;
        bit              mapped;
        bit              tmo;
        int              done;
        logic            exp_err;
        mapped   = (sel < N_AP);
        sel_mask = '0;
        if (mapped) sel_mask[sel] = 1'b1;
        tmo  = mapped && abort_at == 0 && lat >= TIMEOUT;
        done = !mapped ? 1 : (abort_at != 0) ? abort_at + 1 : tmo ? TIMEOUT + 1 : lat + 1;
        exp_err = !mapped ? 1'b1 : (abort_at != 0) ? 1'b0 : tmo ? 1'b1 : err_bit;

        @(negedge swclk);
        addr = 6'($urandom);
        wd   = $urandom;
        up_sel = 8'(sel); up_addr = addr; up_wdata = wd;
        up_wen = wr; up_ren = !wr; up_abort = 1'b0;
        rand_aps();
        #1;
        check("req_wen", dn_wen, wr ? sel_mask : '0);
        check("req_ren", dn_ren, wr ? '0 : sel_mask);
        check("req_addr", dn_addr, addr);
        check("req_wdata", dn_wdata, wd);
        check("req_rdy", up_rdy, 1);
        check("req_abort", dn_abort, 0);

        for (int c = 1; c <= done + 1; c++) begin
            @(negedge swclk);
            up_wen = 1'b0; up_ren = 1'b0;
            up_sel = 8'($urandom); up_addr = 6'($urandom); up_wdata = $urandom;
            up_abort = (c == abort_at);
            rand_aps();
            if (mapped) begin
                dn_rdy[sel] = (c > lat) || (abort_at != 0 && c > abort_at) || (tmo && c > TIMEOUT);
                dn_err[sel] = err_bit;
                if (c >= done) dn_rdata[32*sel +: 32] = data;
            end
            #1;
            check("rdy", up_rdy, (c >= done));
            check("err", up_err, (c == done) ? exp_err : 1'b0);
            check("abort", dn_abort,
                  (c == abort_at || (tmo && c == TIMEOUT)) ? sel_mask : '0);
            check("idle_strobe", {dn_wen, dn_ren}, 0);
            if (c >= done) check("rdata", up_rdata, mapped ? ap_word(sel) : 32'h0);
        end
        last_sel    = sel;
        last_mapped = mapped;
    endtask

    // Idle cycles with SELECT rewritten: response routing must not move.
    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge swclk);
            up_wen = 1'b0; up_ren = 1'b0; up_abort = 1'b0;
            up_sel = 8'($urandom);
            rand_aps();
            #1;
            check("idle_rdy", up_rdy, 1);
            check("idle_err", up_err, 0);
            check("idle_rdata", up_rdata, last_mapped ? ap_word(last_sel) : 32'h0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int sel, lat, abort_at;
        rand_aps();
        #3;
        check("rst_rdy", up_rdy, 1);
        check("rst_err", up_err, 0);
        check("rst_rdata", up_rdata, ap_word(0));
        check("rst_strobes", {dn_wen, dn_ren, dn_abort}, 0);
        repeat (3) @(negedge swclk);
        rst_n = 1'b1;

        run_txn(1, 1'b0, 3, 1'b0, 0, 32'h12345678);
        run_txn(0, 1'b1, 2, 1'b0, 0, $urandom);
        idle_check(4);
        run_txn(5, 1'b0, 0, 1'b0, 0, $urandom);
        idle_check(2);
        run_txn(0, 1'b0, 6, 1'b1, 2, $urandom);
        run_txn(1, 1'b1, 20, 1'b0, 0, $urandom);
        run_txn(1, 1'b1, 9, 1'b1, 0, $urandom);
        run_txn(1, 1'b0, 2, 1'b1, 0, $urandom);

        // Abort with nothing pending still reaches the last selected AP.
        run_txn(0, 1'b0, 1, 1'b0, 0, $urandom);
        @(negedge swclk);
        up_abort = 1'b1;
        #1;
        check("idle_abort", dn_abort, 2'b01);
        check("idle_abort_rdy", up_rdy, 1);
        idle_check(1);

        // Reset while an AP1 read is pending.
        @(negedge swclk);
        up_sel = 8'd1; up_ren = 1'b1; dn_rdy = '0;
        @(negedge swclk);
        up_ren = 1'b0;
        #1;
        check("mid_pending", up_rdy, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", up_rdy, 1);
        check("mid_rst_err", up_err, 0);
        check("mid_rst_rdata", up_rdata, ap_word(0));
        repeat (2) @(negedge swclk);
        rst_n = 1'b1;
        last_sel = 0; last_mapped = 1'b1;
        run_txn(0, 1'b0, 3, 1'b0, 0, 32'h12345678);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 9) < 8) sel = $urandom_range(0, N_AP - 1);
            else sel = $urandom_range(N_AP, 255);
            lat = $urandom_range(0, 7);
            abort_at = 0;
            if (sel < N_AP && lat >= 1 && $urandom_range(0, 3) == 0)
                abort_at = $urandom_range(1, (lat < TIMEOUT - 1) ? lat : TIMEOUT - 1);
            run_txn(sel, 1'($urandom), lat, 1'($urandom), abort_at, $urandom);
            idle_check($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
